// File: rtl/temporal_encoder.sv
// Temporal N-gram encoder: sliding history of spatial hypervectors, XOR-bound by age rotation.
// Optional macro TEMPORAL_FLUSH_EN adds FlushIn_SI to clear the history at label boundaries.
module temporal_encoder #(
    parameter int HV_DIMENSION = 2000,
    parameter int NGRAM_SIZE   = 4
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
`ifdef TEMPORAL_FLUSH_EN
    input  logic                    FlushIn_SI,
`endif
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

    localparam int CW = $clog2(NGRAM_SIZE) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(NGRAM_SIZE - 1);

    typedef enum logic {FILLING, STEADY} state_e;
    localparam state_e RST_STATE = (NGRAM_SIZE == 1) ? STEADY : FILLING;

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [0:HV_DIMENSION-1]   hist_q [NGRAM_SIZE];
    logic [0:HV_DIMENSION-1]   hist_d [NGRAM_SIZE];
    logic                      valid_q, valid_d;
    logic [0:HV_DIMENSION-1]   data_q, data_d;
    logic [0:HV_DIMENSION-1]   ngram;
    logic                      flush, accept, out_fire, load;

`ifdef TEMPORAL_FLUSH_EN
    assign flush = FlushIn_SI;
`else
    assign flush = 1'b0;
`endif

    // rho^amt: index i takes bit i-amt, i.e. a numeric rotate right
    function automatic logic [0:HV_DIMENSION-1] rotr(
        input logic [0:HV_DIMENSION-1] x,
        input int                      amt
    );
        int a;
        a = amt % HV_DIMENSION;
        if (a == 0) return x;
        return (x >> a) | (x << (HV_DIMENSION - a));
    endfunction

    assign ReadyOut_SO = !valid_q || ReadyIn_SI;
    assign accept      = ValidIn_SI && ReadyOut_SO;
    assign out_fire    = valid_q && ReadyIn_SI;

    always_comb begin
        ngram = HypervectorIn_DI;
        for (int k = 0; k < NGRAM_SIZE - 1; k++) begin
            ngram = ngram ^ rotr(hist_q[k], k + 1);
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        hist_d  = hist_q;
        valid_d = valid_q;
        data_d  = data_q;
        load    = 1'b0;

        if (out_fire) valid_d = 1'b0;

        if (flush) begin
            hist_d = '{default: '0};
            cnt_d  = '0;
        end

        if (accept) begin
            hist_d[0] = HypervectorIn_DI;
            for (int k = 1; k < NGRAM_SIZE; k++) begin
                hist_d[k] = flush ? '0 : hist_q[k-1];
            end
            if (flush) begin
                cnt_d = (CNT_MAX == '0) ? '0 : CW'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
            unique case (state_q)
                FILLING: load = 1'b0;
                STEADY:  load = !flush || (NGRAM_SIZE == 1);
            endcase
        end

        if (load) begin
            valid_d = 1'b1;
            data_d  = ngram;
        end

        state_d = (cnt_d == CNT_MAX) ? STEADY : FILLING;
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            hist_q  <= '{default: '0};
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ValidOut_SO       = valid_q;
    assign HypervectorOut_DO = data_q;

endmodule

// File: tb/tb_temporal_encoder.sv
// Self-checking bench for temporal_encoder (D=8, N=3): directed table,
// reset/flush sequences and randomized traffic against a queue-based model.
module tb_temporal_encoder;

    localparam int D = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         vin;
    logic         rdy_in;
    logic [0:D-1] hv_in;
    logic         rdy_out;
    logic         vout;
    logic [0:D-1] hv_out;
`ifdef TEMPORAL_FLUSH_EN
    logic         flush;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    temporal_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(N)) dut (
        .Clk_CI           (clk),
        .Reset_RI         (rst),
        .ValidIn_SI       (vin),
        .ReadyOut_SO      (rdy_out),
        .HypervectorIn_DI (hv_in),
        .ValidOut_SO      (vout),
        .ReadyIn_SI       (rdy_in),
`ifdef TEMPORAL_FLUSH_EN
        .FlushIn_SI       (flush),
`endif
        .HypervectorOut_DO(hv_out)
    );

    // Reference model: accepted vectors since last clear, newest first
    logic [0:D-1] m_hist[$];
    logic         m_ov;
    logic [0:D-1] m_od;

    function automatic logic [0:D-1] m_rot(input logic [0:D-1] x, input int k);
        logic [0:D-1] r;
        for (int i = 0; i < D; i++) r[i] = x[(i - k + 4 * D) % D];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input bit v, input bit r, input logic [0:D-1] hv,
                        input bit rs, input bit fl, output bit rdy_seen);
        bit           acc;
        logic [0:D-1] ng;
        @(negedge clk);
        vin = v; rdy_in = r; hv_in = hv; rst = rs;
`ifdef TEMPORAL_FLUSH_EN
        flush = fl;
`endif
        #1;
        rdy_seen = rdy_out;
        chk("ready", 32'(rdy_out), 32'(!m_ov || r));
        acc = v && (!m_ov || r);
        if (rs) begin
            m_hist.delete();
            m_ov = 1'b0;
            m_od = '0;
        end else begin
            if (m_ov && r) m_ov = 1'b0;
            if (fl) m_hist.delete();
            if (acc) begin
                if (m_hist.size() >= N - 1) begin
                    ng = hv;
                    for (int k = 1; k < N; k++) ng = ng ^ m_rot(m_hist[k-1], k);
                    m_ov = 1'b1;
                    m_od = ng;
                end
                m_hist.push_front(hv);
                while (m_hist.size() > N - 1) void'(m_hist.pop_back());
            end
        end
        @(posedge clk);
        #1;
        chk("valid", 32'(vout), 32'(m_ov));
        if (m_ov) chk("data", 32'(hv_out), 32'(m_od));
    endtask

    typedef struct {
        bit           v;
        bit           r;
        logic [0:D-1] hv;
        bit           exp_ready;
        bit           exp_valid;
        logic [0:D-1] exp_out;
    } vec_t;

    vec_t tbl[$];
    bit   rs_seen;

    initial begin
        vin = 0; rdy_in = 1; hv_in = '0; rst = 1;
`ifdef TEMPORAL_FLUSH_EN
        flush = 0;
`endif
        m_ov = 0; m_od = '0;

        step(0, 1, '0, 1, 0, rs_seen);
        chk("rst_valid", 32'(vout), 32'(0));
        chk("rst_data", 32'(hv_out), 32'(0));
        chk("rst_ready", 32'(rdy_out), 32'(1));

        // Fill, slide, back-pressure, release, drain
        tbl.push_back('{1, 1, 8'b10000000, 1, 0, 8'h00});
        tbl.push_back('{1, 1, 8'b00000000, 1, 0, 8'h00});
        tbl.push_back('{1, 1, 8'b00000000, 1, 1, 8'b00100000});
        tbl.push_back('{1, 1, 8'b11111111, 1, 1, 8'b11111111});
        for (int i = 0; i < 5; i++) tbl.push_back('{1, 0, 8'h55, 0, 1, 8'hFF});
        tbl.push_back('{1, 1, 8'h55, 1, 1, 8'hAA});
        tbl.push_back('{0, 1, 8'h00, 1, 0, 8'h00});

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].r, tbl[i].hv, 0, 0, rs_seen);
            chk($sformatf("tbl%0d_ready", i), 32'(rs_seen), 32'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d_valid", i), 32'(vout), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_out", i), 32'(hv_out), 32'(tbl[i].exp_out));
        end

        // Reset while an output is pending
        step(1, 0, 8'h13, 0, 0, rs_seen);
        step(1, 0, 8'h24, 0, 0, rs_seen);
        step(1, 0, 8'h35, 0, 0, rs_seen);
        chk("pre_rst_valid", 32'(vout), 32'(1));
        step(1, 0, 8'h46, 1, 0, rs_seen);
        chk("midrst_valid", 32'(vout), 32'(0));
        chk("midrst_data", 32'(hv_out), 32'(0));
        chk("midrst_ready", 32'(rdy_out), 32'(1));
        step(1, 1, 8'h81, 0, 0, rs_seen);
        chk("refill1_valid", 32'(vout), 32'(0));
        step(1, 1, 8'h42, 0, 0, rs_seen);
        chk("refill2_valid", 32'(vout), 32'(0));
        step(1, 1, 8'h18, 0, 0, rs_seen);
        chk("refill3_valid", 32'(vout), 32'(1));
        chk("refill3_out", 32'(hv_out), 32'(8'h18 ^ 8'h21 ^ 8'h60));

`ifdef TEMPORAL_FLUSH_EN
        step(0, 1, '0, 1, 0, rs_seen);
        step(1, 1, 8'hF0, 0, 0, rs_seen);
        step(1, 1, 8'h0F, 0, 0, rs_seen);
        step(1, 1, 8'h80, 0, 1, rs_seen);
        chk("flush_e_valid", 32'(vout), 32'(0));
        step(1, 1, 8'h00, 0, 0, rs_seen);
        chk("flush_f_valid", 32'(vout), 32'(0));
        step(1, 1, 8'h00, 0, 0, rs_seen);
        chk("flush_g_valid", 32'(vout), 32'(1));
        chk("flush_g_out", 32'(hv_out), 32'(8'b00100000));
`endif

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 8'($urandom), $urandom_range(0, 59) == 0,
`ifdef TEMPORAL_FLUSH_EN
                 $urandom_range(0, 29) == 0,
`else
                 1'b0,
`endif
                 rs_seen);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/temporal_encoder.md
# temporal_encoder

Temporal N-gram encoder sitting directly downstream of the spatial encoder. It accepts one spatial hypervector per handshake and keeps a sliding history of the last `NGRAM_SIZE` vectors. For every accepted vector once the history is full, it emits the N-gram hypervector: the XOR-binding of each history entry rotated by its age. Its output feeds the associative memory stage.

## Interface
- `HV_DIMENSION`, default `HV_DIMENSION` from const.vh (2000): hypervector width in bits, big-endian indexed `[0:HV_DIMENSION-1]`.
- `NGRAM_SIZE`, default 4: N-gram length; legal range 1..16.
- `Clk_CI` input 1: single clock; all state changes on its rising edge.
- `Reset_RI` input 1: synchronous, active-high reset.
- `ValidIn_SI` input 1: the spatial hypervector on `HypervectorIn_DI` is valid.
- `ReadyOut_SO` output 1: the encoder can accept an input this cycle.
- `HypervectorIn_DI` input `HV_DIMENSION`: spatial hypervector, driven by the spatial encoder's `HypervectorOut_DO`.
- `ValidOut_SO` output 1: `HypervectorOut_DO` holds a valid N-gram.
- `ReadyIn_SI` input 1: the downstream stage accepts the output this cycle.
- `HypervectorOut_DO` output `HV_DIMENSION`: registered N-gram hypervector.
- `FlushIn_SI` input 1: present only with `TEMPORAL_FLUSH_EN` (see Configuration).

## Operation
- Accept: input handshake fires when `ValidIn_SI && ReadyOut_SO`. Output handshake fires when `ValidOut_SO && ReadyIn_SI`.
- Ready: `ReadyOut_SO = !ValidOut_SO || ReadyIn_SI`. This is combinational, with a bypass when the output slot is being drained in the same cycle.
- History: `Hist[0..NGRAM_SIZE-1]`, where `Hist[0]` is the newest entry.
  - On accept, every entry shifts: `Hist[k] <= Hist[k-1]` for k ≥ 1, and `Hist[0] <= HypervectorIn_DI`.
  - The oldest entry is dropped.
- Rotation: `rho(x)` is a rotate right by one bit position: `rho(x)[0] = x[D-1]` and `rho(x)[i] = x[i-1]`. `rho^k` applies the rotation k times.
- N-gram: `NG = In ^ rho(Hist[0]) ^ rho^2(Hist[1]) ^ … ^ rho^(N-1)(Hist[N-2])`. It is computed combinationally from the incoming vector and the pre-shift history.
- Fill counter: `FillCntr`, width `ceilLog2(NGRAM_SIZE)+1`, range 0..N-1.
  - Increments on each accept.
  - Saturates at N-1; it never wraps.
- FSM states:
  - FILLING: `FillCntr < N-1`. An accept increments the counter; no output is produced. The FSM moves to STEADY when the counter reaches N-1.
  - STEADY: every accept loads `NG` into the output register and sets `ValidOut_SO`. Stride is 1: each new vector produces one N-gram.
- Output register:
  - Holds its value and `ValidOut_SO` until the output handshake.
  - On an output handshake with no simultaneous load, `ValidOut_SO` clears; the data value is don't-care and is held.
  - On a simultaneous output handshake and load, the new N-gram replaces the old one and `ValidOut_SO` stays 1.
- `NGRAM_SIZE` = 1: the block always runs in STEADY. The output equals the input, delayed one cycle.

## Timing
- Latency: 1 cycle. An input accepted at edge t gives `ValidOut_SO` = 1 after edge t.
- Throughput: one vector per cycle while `ReadyIn_SI` is held high.
- Back-pressure: when `ValidOut_SO`=1 and `ReadyIn_SI`=0, `ReadyOut_SO`=0. History and counter are frozen, and any input is not consumed.
- Reset values:
  - `ValidOut_SO`=0, `HypervectorOut_DO`=0, `ReadyOut_SO`=1.
  - History all zeros, `FillCntr`=0, state FILLING.
- Reset asserted mid-operation discards the pending output and partial history on that edge. Reset has priority over every other input.
- `ValidIn_SI` while `ReadyOut_SO`=0: ignored. It must be held by the upstream stage.

## Configuration
- Macro: `TEMPORAL_FLUSH_EN`.
- Defined: adds port `FlushIn_SI` (input, 1 bit), used at gesture or label boundaries.
  - A flush clears `FillCntr` to 0 and zeroes the history.
  - A flush does not affect a pending output.
  - If a flush coincides with an input accept, the flush wins: history becomes {In, 0, …}, `FillCntr`=1 (STEADY if N=1), and no N-gram is emitted unless N=1.
- Undefined: the port is absent. History can be cleared only by `Reset_RI`.

## Test plan
All scenarios use D=8 and N=3, with bit 0 as the leftmost bit.
- Fill: feed A=10000000, B=00000000, C=00000000 with `ReadyIn_SI`=1.
  - No output after A or B.
  - After C: `ValidOut_SO`=1, `HypervectorOut_DO`=00100000.
- Slide: continue from Fill with D=11111111. Next cycle the output is 11111111 (D ^ rho(C) ^ rho²(B)).
- Back-pressure: with `ValidOut_SO`=1, hold `ReadyIn_SI`=0 for 5 cycles with `ValidIn_SI`=1.
  - `ReadyOut_SO`=0 and the output is stable for all 5 cycles.
  - When `ReadyIn_SI` rises, the input is accepted that same cycle and the new N-gram appears the next cycle.
- Reset mid-stream: assert `Reset_RI` while `ValidOut_SO`=1.
  - Next cycle: `ValidOut_SO`=0, output 0, `ReadyOut_SO`=1.
  - The next output appears only after 3 new accepts.
- Flush (with `TEMPORAL_FLUSH_EN`): fill 2 vectors, then pulse `FlushIn_SI` together with input E.
  - No output after E.
  - The output appears after 2 further accepts, computed from E only and not from earlier history.
